tpu_bram_port_arbiter: RTL and testbench
========================================

# tpu_bram_port_arbiter

Two-requester arbiter that shares one external port of a matrix BRAM (A, B or C) between the host-side loader and the matmul engine. It sits between the `bram_*_ext` port of `top` and the two masters. One instance serves each BRAM. It provides registered round-robin grant, optional burst-limited handover, and returns read data with a per-requester valid strobe.

## Interface
Parameters:
- `AWIDTH`, 10, BRAM address width
- `DWIDTH`, 8, element width
- `MAT_MUL_SIZE`, 4, elements per BRAM word; word width is `MAT_MUL_SIZE*DWIDTH`
- `MASK_WIDTH`, 4, byte-lane write mask width (equal to `MAT_MUL_SIZE`)
- `MAX_BURST`, 16, accesses per tenure before forced handover; range 2..255

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk`, in, 1, single clock
  - `resetn`, in, 1, synchronous active-low reset
- Per requester, where `x` is `h` (host) or `e` (engine):
  - `x_req`, in, 1, access request; held with address and data until granted
  - `x_addr`, in, `AWIDTH`, word address
  - `x_wdata`, in, `MAT_MUL_SIZE*DWIDTH`, write data
  - `x_we`, in, `MASK_WIDTH`, write lane mask; all-zero means read
  - `x_gnt`, out, 1, registered grant; an access occurs in any cycle with `x_req && x_gnt`
  - `x_rvalid`, out, 1, read data valid for this requester
- Shared read data and BRAM side:
  - `rdata`, out, `MAT_MUL_SIZE*DWIDTH`, broadcast of `bram_rdata`
  - `bram_addr`, out, `AWIDTH`, to BRAM
  - `bram_wdata`, out, `MAT_MUL_SIZE*DWIDTH`, to BRAM
  - `bram_we`, out, `MASK_WIDTH`, to BRAM
  - `bram_rdata`, in, `MAT_MUL_SIZE*DWIDTH`, from BRAM; 1-cycle registered read

## Operation
- State machine has three states: IDLE, OWN_H and OWN_E. `h_gnt = (state==OWN_H)` and `e_gnt = (state==OWN_E)`, both driven straight from the state flop.
- `last` flop records the most recently served requester. Reset value is engine, so the host wins the first tie.
- Transitions from IDLE:
  - Exactly one request present: go to that requester's OWN state.
  - Both requests present: go to the requester that is not `last`.
  - No request: stay in IDLE.
- Transitions from OWN_x:
  - `x_req` low: go to the other OWN state if the other requester is requesting, else IDLE.
  - `x_req` high and the burst limit is hit while the other requester is requesting: go to the other OWN state.
  - Otherwise: stay in OWN_x.
- The handover is bubble-free: the new owner is granted in the next cycle.
- `last` updates to x on every entry into OWN_x.
- Burst counter, 8 bits:
  - Clears on every state change.
  - Increments on each access cycle and saturates at `MAX_BURST`.
  - The limit is hit when an access occurs with count == `MAX_BURST-1`.
  - With no competing request, the owner keeps the port past the limit.
- BRAM mux:
  - In OWN_x, `bram_addr`/`bram_wdata` follow `x_addr`/`x_wdata`, and `bram_we = x_req ? x_we : 0`.
  - In IDLE, `bram_addr=0`, `bram_wdata=0`, `bram_we=0`.
- Read return: `x_rvalid` is registered and equals the previous cycle's `x_req && x_gnt && (x_we==0)`. `rdata = bram_rdata`, combinational passthrough.

## Timing
- Reset (`resetn` low at a `clk` edge):
  - state=IDLE, `last`=engine, counter=0.
  - `h_gnt=0`, `e_gnt=0`, `h_rvalid=0`, `e_rvalid=0`.
  - `bram_we=0`, `bram_addr=0`, `bram_wdata=0`.
  - A reset asserted mid-burst aborts the tenure. A read issued in the cycle before reset does not produce `rvalid`.
- Grant latency: a request raised in cycle t is granted in cycle t+1 from IDLE. Its earliest access is t+1, and `rvalid` for a read is at t+2.
- Write takes effect at the BRAM edge ending the access cycle.
- Back-to-back reads: one access per cycle, with `rvalid` pipelined one cycle behind each.
- Handover: the last access of the old owner is in cycle t and the first access of the new owner is in t+1. A read by the old owner in cycle t still returns `rvalid` to the old owner in t+1.
- A requester that loses its grant while `x_req` is high must hold its request fields unchanged until it is re-granted.

## Configuration
- `ARB_BURST_LIMIT_EN`:
  - Defined: the burst counter and forced handover at `MAX_BURST` accesses are compiled in.
  - Undefined: counter logic is removed, and the owner keeps the port until it deasserts `x_req`.
  - All other behaviour is identical in both builds.

## Test plan
- Reset values: hold `resetn=0` for 3 cycles with both requests high -> `h_gnt`, `e_gnt`, `h_rvalid`, `e_rvalid` and `bram_we` are all 0. After release, `h_gnt=1` one cycle later.
- Single host write then read: host writes 0x04030201 to addr 5 with `we=4'hF`, then reads addr 5 -> `h_rvalid=1` one cycle after the read access, `rdata=0x04030201`, `e_rvalid` stays 0.
- Tie from IDLE after reset: both raise `req` in the same cycle -> host granted first. After the host drops `req`, the engine is granted next cycle with no IDLE cycle. A second simultaneous tie is then won by the host, since `last`=engine.
- Burst limit (`ARB_BURST_LIMIT_EN`, `MAX_BURST=16`): host streams 20 reads while the engine requests continuously -> exactly 16 host accesses, then `e_gnt` in the following cycle. The 16th host read still yields `h_rvalid`.
- Burst limit without contention, or with the macro undefined: host streams 40 accesses while the engine is idle (macro defined), or while the engine requests (macro undefined) -> host keeps the grant for all 40.
- Reset mid-operation: pull `resetn` low during engine read access #3 -> no `e_rvalid` in the next cycle, and all outputs match the reset values.

Source files
------------

// File: rtl/tpu_bram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// tpu_bram_port_arbiter_if
// One requester's view of a shared matrix-BRAM port.
//   req    : access request, held with addr/wdata/we until granted
//   addr   : word address
//   wdata  : write data, MAT_MUL_SIZE*DWIDTH bits
//   we     : byte-lane write mask, all-zero means read
//   gnt    : registered grant; an access happens on every req && gnt cycle
//   rvalid : read data valid for this requester, one cycle after a read
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface tpu_bram_port_arbiter_if #(
  parameter int AWIDTH       = 10,
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int MASK_WIDTH   = 4
) ();
  logic                           req;
  logic [AWIDTH-1:0]              addr;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] wdata;
  logic [MASK_WIDTH-1:0]          we;
  logic                           gnt;
  logic                           rvalid;

  modport master (output req, addr, wdata, we, input gnt, rvalid);
  modport slave  (input req, addr, wdata, we, output gnt, rvalid);
endinterface

// File: rtl/tpu_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tpu_bram_port_arbiter
// Shares one external port of a matrix BRAM between the host loader (h) and
// the matmul engine (e). Registered round-robin grant with bubble-free
// handover, optional burst-limited tenure, per-requester read-valid strobe.
//
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   h, e         : requester ports (tpu_bram_port_arbiter_if.slave)
//   rdata        : broadcast of bram_rdata to both requesters
//   bram_addr    : address to BRAM
//   bram_wdata   : write data to BRAM
//   bram_we      : byte-lane write enable to BRAM
//   bram_rdata   : BRAM read data (1-cycle registered read)
//
// Build option: define ARB_BURST_LIMIT_EN to compile in the burst counter
// that forces a handover after MAX_BURST accesses when the other requester
// is waiting. Without it the owner keeps the port until it drops req.
// ---------------------------------------------------------------------------
module tpu_bram_port_arbiter #(
  parameter int AWIDTH       = 10,
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int MASK_WIDTH   = 4,
  parameter int MAX_BURST    = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  tpu_bram_port_arbiter_if.slave         h,
  tpu_bram_port_arbiter_if.slave         e,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] rdata,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
  output logic [MASK_WIDTH-1:0]          bram_we,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_H = 2'd1,
    OWN_E = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   last_e_r;     // 1: engine was served most recently, 0: host
  logic   h_rvalid_r;
  logic   e_rvalid_r;
  logic   h_acc_s;
  logic   e_acc_s;
  logic   h_rd_s;
  logic   e_rd_s;
  logic   limit_hit_s;

  if ((MAX_BURST < 2) || (MAX_BURST > 255)) begin : g_bad_max_burst
    $error("MAX_BURST must be in 2..255");
  end

  assign h_acc_s = h.req && (state_r == OWN_H);
  assign e_acc_s = e.req && (state_r == OWN_E);
  assign h_rd_s  = h_acc_s && (h.we == {MASK_WIDTH{1'b0}});
  assign e_rd_s  = e_acc_s && (e.we == {MASK_WIDTH{1'b0}});

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [7:0] BURST_LAST_C = 8'(MAX_BURST - 1);
  localparam logic [7:0] BURST_MAX_C  = 8'(MAX_BURST);

  logic [7:0] burst_cnt_r;

  // The limit fires on the access that would be number MAX_BURST.
  assign limit_hit_s = (h_acc_s || e_acc_s) && (burst_cnt_r == BURST_LAST_C);

  // Burst counter: clears on every tenure change, saturates at MAX_BURST.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      burst_cnt_r <= 8'd0;
    end else if (state_nxt_s != state_r) begin
      burst_cnt_r <= 8'd0;
    end else if ((h_acc_s || e_acc_s) && (burst_cnt_r != BURST_MAX_C)) begin
      burst_cnt_r <= burst_cnt_r + 8'd1;
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end
`else
  assign limit_hit_s = 1'b0;
`endif

  // State, round-robin history and read-valid registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= IDLE;
      last_e_r   <= 1'b1;
      h_rvalid_r <= 1'b0;
      e_rvalid_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      h_rvalid_r <= h_rd_s;
      e_rvalid_r <= e_rd_s;
      if (state_nxt_s == OWN_H) begin
        last_e_r <= 1'b0;
      end else if (state_nxt_s == OWN_E) begin
        last_e_r <= 1'b1;
      end else begin
        last_e_r <= last_e_r;
      end
    end
  end

  // Next-state selection and BRAM port mux.
  always_comb begin
    state_nxt_s = state_r;
    bram_addr   = {AWIDTH{1'b0}};
    bram_wdata  = {(MAT_MUL_SIZE*DWIDTH){1'b0}};
    bram_we     = {MASK_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        // On a tie the requester not served last wins.
        if (h.req && e.req) begin
          state_nxt_s = last_e_r ? OWN_H : OWN_E;
        end else if (h.req) begin
          state_nxt_s = OWN_H;
        end else if (e.req) begin
          state_nxt_s = OWN_E;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN_H: begin
        bram_addr  = h.addr;
        bram_wdata = h.wdata;
        bram_we    = h.req ? h.we : {MASK_WIDTH{1'b0}};
        if (!h.req) begin
          state_nxt_s = e.req ? OWN_E : IDLE;
        end else if (limit_hit_s && e.req) begin
          state_nxt_s = OWN_E;
        end else begin
          state_nxt_s = OWN_H;
        end
      end
      OWN_E: begin
        bram_addr  = e.addr;
        bram_wdata = e.wdata;
        bram_we    = e.req ? e.we : {MASK_WIDTH{1'b0}};
        if (!e.req) begin
          state_nxt_s = h.req ? OWN_H : IDLE;
        end else if (limit_hit_s && h.req) begin
          state_nxt_s = OWN_H;
        end else begin
          state_nxt_s = OWN_E;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign h.gnt    = (state_r == OWN_H);
  assign e.gnt    = (state_r == OWN_E);
  assign h.rvalid = h_rvalid_r;
  assign e.rvalid = e_rvalid_r;
  assign rdata    = bram_rdata;

endmodule

// File: tb/tb_tpu_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tpu_bram_port_arbiter
// Directed bench for tpu_bram_port_arbiter with a behavioural BRAM
// (1-cycle registered read, byte-lane writes). Inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_tpu_bram_port_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int MMS = 4;
  localparam int MW  = 4;
  localparam int WW  = MMS * DW;

  localparam logic [WW-1:0] HD = 32'h04030201;
  localparam logic [WW-1:0] ED = 32'hA1B2C3D4;
  localparam logic [WW-1:0] ZD = 32'h00000000;
  localparam logic [WW-1:0] M7 = 32'h00B200D4; // ED written with lanes 0 and 2

`ifdef ARB_BURST_LIMIT_EN
  localparam int STREAM_N   = 20;
  localparam int EXP_TENURE = 16;
`else
  localparam int STREAM_N   = 40;
  localparam int EXP_TENURE = 40;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic [WW-1:0] rdata;
  logic [AW-1:0] bram_addr;
  logic [WW-1:0] bram_wdata;
  logic [MW-1:0] bram_we;
  logic [WW-1:0] bram_rdata;
  logic [WW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tpu_bram_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW), .MAT_MUL_SIZE(MMS), .MASK_WIDTH(MW)) h_if ();
  tpu_bram_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW), .MAT_MUL_SIZE(MMS), .MASK_WIDTH(MW)) e_if ();

  tpu_bram_port_arbiter #(
    .AWIDTH(AW), .DWIDTH(DW), .MAT_MUL_SIZE(MMS), .MASK_WIDTH(MW), .MAX_BURST(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .h(h_if),
    .e(e_if),
    .rdata(rdata),
    .bram_addr(bram_addr),
    .bram_wdata(bram_wdata),
    .bram_we(bram_we),
    .bram_rdata(bram_rdata)
  );

  // Behavioural BRAM: read-old-data, byte-lane masked write.
  always @(posedge clk) begin
    for (int i = 0; i < MW; i++) begin
      if (bram_we[i]) mem[bram_addr][i*8 +: 8] <= bram_wdata[i*8 +: 8];
    end
    bram_rdata <= mem[bram_addr];
  end

  typedef struct {
    logic          rst_n;
    logic          h_req;
    logic [AW-1:0] h_addr;
    logic [WW-1:0] h_wdata;
    logic [MW-1:0] h_we;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic [WW-1:0] e_wdata;
    logic [MW-1:0] e_we;
    logic          x_hgnt;
    logic          x_egnt;
    logic          x_hrv;
    logic          x_erv;
    logic [MW-1:0] x_bwe;
    logic [AW-1:0] x_baddr;
    logic [WW-1:0] x_bwd;
    logic          chk_rd;
    logic [WW-1:0] x_rd;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic hr, input logic [AW-1:0] ha,
                       input logic [WW-1:0] hw, input logic [MW-1:0] hwe,
                       input logic er, input logic [AW-1:0] ea,
                       input logic [WW-1:0] ew, input logic [MW-1:0] ewe);
    resetn     = rst_n;
    h_if.req   = hr;
    h_if.addr  = ha;
    h_if.wdata = hw;
    h_if.we    = hwe;
    e_if.req   = er;
    e_if.addr  = ea;
    e_if.wdata = ew;
    e_if.we    = ewe;
  endtask

  initial begin
    int  hacc;
    int  gcnt;
    int  lost;
    logic prev_hrd;
    logic handed;

    // rst, hreq, haddr, hwdata, hwe, ereq, eaddr, ewdata, ewe | hgnt, egnt, hrv, erv, bwe, baddr, bwdata, chk_rd, rdata
    vecs[0]  = '{1'b0, 1'b1, 10'd5, HD, 4'h0, 1'b1, 10'd9, ZD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, ZD, 1'b0, ZD};
    vecs[1]  = '{1'b0, 1'b1, 10'd5, HD, 4'h0, 1'b1, 10'd9, ZD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, ZD, 1'b0, ZD};
    vecs[2]  = '{1'b0, 1'b1, 10'd5, HD, 4'h0, 1'b1, 10'd9, ZD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, ZD, 1'b0, ZD};
    vecs[3]  = '{1'b1, 1'b1, 10'd5, HD, 4'hF, 1'b1, 10'd9, ZD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, ZD, 1'b0, ZD};
    vecs[4]  = '{1'b1, 1'b1, 10'd5, HD, 4'hF, 1'b1, 10'd9, ZD, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 10'd5, HD, 1'b0, ZD};
    vecs[5]  = '{1'b1, 1'b1, 10'd5, HD, 4'h0, 1'b1, 10'd9, ZD, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'd5, HD, 1'b0, ZD};
    vecs[6]  = '{1'b1, 1'b0, 10'd5, HD, 4'h0, 1'b1, 10'd9, ZD, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 10'd5, HD, 1'b1, HD};
    vecs[7]  = '{1'b1, 1'b0, 10'd5, HD, 4'h0, 1'b1, 10'd9, ZD, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 10'd9, ZD, 1'b0, ZD};
    vecs[8]  = '{1'b1, 1'b0, 10'd5, HD, 4'h0, 1'b0, 10'd9, ZD, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 10'd9, ZD, 1'b0, ZD};
    vecs[9]  = '{1'b1, 1'b1, 10'd5, HD, 4'h0, 1'b1, 10'd9, ZD, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, ZD, 1'b0, ZD};
    vecs[10] = '{1'b1, 1'b1, 10'd5, HD, 4'h0, 1'b1, 10'd9, ZD, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'd5, HD, 1'b0, ZD};
    vecs[11] = '{1'b1, 1'b0, 10'd5, HD, 4'h0, 1'b1, 10'd7, ED, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 10'd5, HD, 1'b1, HD};
    vecs[12] = '{1'b1, 1'b0, 10'd5, HD, 4'h0, 1'b1, 10'd7, ED, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 10'd7, ED, 1'b0, ZD};
    vecs[13] = '{1'b1, 1'b0, 10'd5, HD, 4'h0, 1'b1, 10'd7, ED, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 10'd7, ED, 1'b0, ZD};
    vecs[14] = '{1'b1, 1'b0, 10'd5, HD, 4'h0, 1'b0, 10'd7, ED, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 10'd7, ED, 1'b1, M7};
    vecs[15] = '{1'b1, 1'b0, 10'd5, HD, 4'h0, 1'b0, 10'd7, ED, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, ZD, 1'b0, ZD};

    drive(1'b0, 1'b1, 10'd5, HD, 4'h0, 1'b1, 10'd9, ZD, 4'h0);
    @(posedge clk);

    // Table: reset, host write/read, ties, handovers, engine masked write/read.
    for (int i = 0; i < 16; i++) begin
      #1;
      drive(vecs[i].rst_n, vecs[i].h_req, vecs[i].h_addr, vecs[i].h_wdata, vecs[i].h_we,
            vecs[i].e_req, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_we);
      @(negedge clk);
      check($sformatf("row%0d_h_gnt", i),      h_if.gnt,    vecs[i].x_hgnt);
      check($sformatf("row%0d_e_gnt", i),      e_if.gnt,    vecs[i].x_egnt);
      check($sformatf("row%0d_h_rvalid", i),   h_if.rvalid, vecs[i].x_hrv);
      check($sformatf("row%0d_e_rvalid", i),   e_if.rvalid, vecs[i].x_erv);
      check($sformatf("row%0d_bram_we", i),    bram_we,     vecs[i].x_bwe);
      check($sformatf("row%0d_bram_addr", i),  bram_addr,   vecs[i].x_baddr);
      check($sformatf("row%0d_bram_wdata", i), bram_wdata,  vecs[i].x_bwd);
      if (vecs[i].chk_rd) check($sformatf("row%0d_rdata", i), rdata, vecs[i].x_rd);
      @(posedge clk);
    end

    // Contended host read stream: tenure length and rvalid pipelining.
    hacc = 0; prev_hrd = 1'b0; handed = 1'b0;
    for (int cyc = 0; cyc < 120 && !handed; cyc++) begin
      #1;
      drive(1'b1, (hacc < STREAM_N), 10'(hacc), ZD, 4'h0, 1'b1, 10'd3, ZD, 4'h0);
      @(negedge clk);
      check("burst_h_rvalid", h_if.rvalid, prev_hrd);
      prev_hrd = h_if.req && h_if.gnt;
      if (h_if.req && h_if.gnt) hacc++;
      if (e_if.gnt) handed = 1'b1;
      @(posedge clk);
    end
    check("burst_handover_seen", handed, 1'b1);
    check("burst_host_accesses", hacc, EXP_TENURE);
    #1;
    drive(1'b1, 1'b0, 10'd0, ZD, 4'h0, 1'b0, 10'd0, ZD, 4'h0);
    repeat (3) @(posedge clk);

    // Uncontended host stream: grant held for all 40 accesses.
    gcnt = 0; lost = 0;
    for (int cyc = 0; cyc < 60 && gcnt < 40; cyc++) begin
      #1;
      drive(1'b1, 1'b1, 10'(cyc), ZD, 4'h0, 1'b0, 10'd0, ZD, 4'h0);
      @(negedge clk);
      if (h_if.gnt) gcnt++;
      else if (gcnt > 0) lost++;
      @(posedge clk);
    end
    check("solo_host_accesses", gcnt, 40);
    check("solo_host_lost_grant", lost, 0);
    #1;
    drive(1'b1, 1'b0, 10'd0, ZD, 4'h0, 1'b0, 10'd0, ZD, 4'h0);
    repeat (3) @(posedge clk);

    // Engine read stream aborted by reset on access #3.
    #1; drive(1'b1, 1'b0, 10'd0, ZD, 4'h0, 1'b1, 10'd7, ZD, 4'h0);
    @(negedge clk); check("rst_seq_req_e_gnt", e_if.gnt, 1'b0);
    @(posedge clk);
    @(negedge clk); check("rst_seq_acc1_e_gnt", e_if.gnt, 1'b1);
    check("rst_seq_acc1_e_rvalid", e_if.rvalid, 1'b0);
    @(posedge clk);
    @(negedge clk); check("rst_seq_acc2_e_gnt", e_if.gnt, 1'b1);
    check("rst_seq_acc2_e_rvalid", e_if.rvalid, 1'b1);
    check("rst_seq_acc2_rdata", rdata, M7);
    @(posedge clk);
    #1; resetn = 1'b0;
    @(negedge clk); check("rst_seq_acc3_e_gnt", e_if.gnt, 1'b1);
    check("rst_seq_acc3_e_rvalid", e_if.rvalid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("rst_seq_after_e_rvalid", e_if.rvalid, 1'b0);
    check("rst_seq_after_h_rvalid", h_if.rvalid, 1'b0);
    check("rst_seq_after_e_gnt", e_if.gnt, 1'b0);
    check("rst_seq_after_h_gnt", h_if.gnt, 1'b0);
    check("rst_seq_after_bram_we", bram_we, 4'h0);
    check("rst_seq_after_bram_addr", bram_addr, 10'd0);
    check("rst_seq_after_bram_wdata", bram_wdata, ZD);
    @(posedge clk);
    #1; resetn = 1'b1;
    @(negedge clk); check("rst_seq_release_e_gnt", e_if.gnt, 1'b0);
    check("rst_seq_release_e_rvalid", e_if.rvalid, 1'b0);
    @(posedge clk);
    @(negedge clk); check("rst_seq_regrant_e_gnt", e_if.gnt, 1'b1);
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
